// File: rtl/speck_key_schedule.sv
// ---------------------------------------------------------------------------
// speck_key_schedule
//   Round-key generator for Speck32/64. Accepts one master key
//   {l2,l1,l0,k0} over a valid/ready handshake, then streams the ROUNDS
//   round keys k0..k(ROUNDS-1) in order over a second valid/ready handshake.
//   Each key comes from one step of the Speck key recurrence applied to
//   registered state. No tables are used.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   key_valid  master key present on key
//   key_ready  block can accept a master key (IDLE only, registered)
//   key        {l2,l1,l0,k0}, k0 in the low WORD_W bits
//   rk_valid   rk/rk_idx/rk_last hold a valid round key
//   rk_ready   downstream accepts rk this cycle
//   rk         round key k_i
//   rk_idx     round index i
//   rk_last    high with rk_valid on the final round key
//   busy       high from key acceptance until the last key is accepted
// ---------------------------------------------------------------------------
module speck_key_schedule #(
   parameter int WORD_W = 16,
   parameter int ROUNDS = 22,
   parameter int ALPHA  = 7,
   parameter int BETA   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  key_valid,
   output logic                  key_ready,
   input  logic [4*WORD_W-1:0]   key,
   output logic                  rk_valid,
   input  logic                  rk_ready,
   output logic [WORD_W-1:0]     rk,
   output logic [4:0]            rk_idx,
   output logic                  rk_last,
   output logic                  busy
);

   localparam logic [4:0] LAST_IDX = 5'(ROUNDS - 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   function automatic logic [WORD_W-1:0] ror(input logic [WORD_W-1:0] x);
      return (x >> ALPHA) | (x << (WORD_W - ALPHA));
   endfunction

   function automatic logic [WORD_W-1:0] rol(input logic [WORD_W-1:0] x);
      return (x << BETA) | (x >> (WORD_W - BETA));
   endfunction

   state_e              state_q, state_d;
   logic [WORD_W-1:0]   k_q, k_d;
   logic [WORD_W-1:0]   l0_q, l0_d;
   logic [WORD_W-1:0]   l1_q, l1_d;
   logic [WORD_W-1:0]   l2_q, l2_d;
   logic [4:0]          i_q, i_d;
   logic                key_ready_q, key_ready_d;
   logic                rk_valid_q, rk_valid_d;
   logic                rk_last_q, rk_last_d;
   logic                busy_q, busy_d;

   logic [WORD_W-1:0]   lnew;

   // One step of the recurrence: the new l word mixes in the round index,
   // and the next k is built from it. Sum wraps mod 2^WORD_W.
   always_comb begin
      lnew = (k_q + ror(l0_q)) ^ WORD_W'(i_q);
   end

   always_comb begin
      state_d = state_q;
      k_d     = k_q;
      l0_d    = l0_q;
      l1_d    = l1_q;
      l2_d    = l2_q;
      i_d     = i_q;

      case (state_q)
         IDLE: begin
            if (key_valid) begin
               k_d     = key[WORD_W-1:0];
               l0_d    = key[2*WORD_W-1:WORD_W];
               l1_d    = key[3*WORD_W-1:2*WORD_W];
               l2_d    = key[4*WORD_W-1:3*WORD_W];
               i_d     = 5'd0;
               state_d = RUN;
            end
         end
         RUN: begin
            // key_valid is deliberately ignored here.
            if (rk_ready) begin
               if (i_q == LAST_IDX) begin
                  state_d = IDLE;
               end else begin
                  k_d  = rol(k_q) ^ lnew;
                  l0_d = l1_q;
                  l1_d = l2_q;
                  l2_d = lnew;
                  i_d  = i_q + 5'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // Handshake outputs are registered: derive them from the next state.
      key_ready_d = (state_d == IDLE);
      rk_valid_d  = (state_d == RUN);
      busy_d      = (state_d == RUN);
      rk_last_d   = (state_d == RUN) && (i_d == LAST_IDX);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         k_q         <= '0;
         l0_q        <= '0;
         l1_q        <= '0;
         l2_q        <= '0;
         i_q         <= '0;
         key_ready_q <= 1'b0;
         rk_valid_q  <= 1'b0;
         rk_last_q   <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         l0_q        <= l0_d;
         l1_q        <= l1_d;
         l2_q        <= l2_d;
         i_q         <= i_d;
         key_ready_q <= key_ready_d;
         rk_valid_q  <= rk_valid_d;
         rk_last_q   <= rk_last_d;
         busy_q      <= busy_d;
      end
   end

   assign key_ready = key_ready_q;
   assign rk_valid  = rk_valid_q;
   assign rk        = k_q;
   assign rk_idx    = i_q;
   assign rk_last   = rk_last_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_speck_key_schedule.sv
// ---------------------------------------------------------------------------
// tb_speck_key_schedule
//   Scoreboard bench for speck_key_schedule. Stimulus pushes the expected
//   key stream (from an array-based model of the Speck key schedule) when a
//   master key is handed over; a negedge monitor pops and compares on every
//   rk transfer and checks that stalled outputs hold stable.
// ---------------------------------------------------------------------------
module tb_speck_key_schedule;

   localparam int W = 16;
   localparam int R = 22;

   typedef struct {
      logic [4:0]   idx;
      logic [W-1:0] rk;
      logic         last;
   } exp_t;

   typedef logic [W-1:0] keys_t [R];

   logic           clk;
   logic           rst_n;
   logic           key_valid;
   logic           key_ready;
   logic [4*W-1:0] key;
   logic           rk_valid;
   logic           rk_ready;
   logic [W-1:0]   rk;
   logic [4:0]     rk_idx;
   logic           rk_last;
   logic           busy;

   int checks   = 0;
   int failures = 0;

   exp_t         sb[$];
   logic [W-1:0] cap [R];

   speck_key_schedule #(.WORD_W(W), .ROUNDS(R), .ALPHA(7), .BETA(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key       (key),
      .rk_valid  (rk_valid),
      .rk_ready  (rk_ready),
      .rk        (rk),
      .rk_idx    (rk_idx),
      .rk_last   (rk_last),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---- reference model (plain Speck32/64 definitions) ----
   function automatic logic [W-1:0] ror16(input logic [W-1:0] x, input int s);
      logic [2*W-1:0] d;
      d = {x, x} >> s;
      return d[W-1:0];
   endfunction

   function automatic logic [W-1:0] rol16(input logic [W-1:0] x, input int s);
      return ror16(x, W - s);
   endfunction

   function automatic keys_t model_keys(input logic [4*W-1:0] mk);
      keys_t        kk;
      logic [W-1:0] ll [R+2];
      kk[0] = mk[15:0];
      ll[0] = mk[31:16];
      ll[1] = mk[47:32];
      ll[2] = mk[63:48];
      for (int i = 0; i < R - 1; i++) begin
         ll[i+3] = (kk[i] + ror16(ll[i], 7)) ^ W'(i);
         kk[i+1] = rol16(kk[i], 2) ^ ll[i+3];
      end
      return kk;
   endfunction

   function automatic logic [31:0] speck_encrypt(input logic [31:0] pt, input keys_t ks);
      logic [W-1:0] x, y;
      x = pt[31:16];
      y = pt[15:0];
      for (int r = 0; r < R; r++) begin
         x = (ror16(x, 7) + y) ^ ks[r];
         y = rol16(y, 2) ^ x;
      end
      return {x, y};
   endfunction

   // ---- monitor ----
   logic         have_prev;
   logic [W-1:0] prev_rk;
   logic [4:0]   prev_idx;
   logic         prev_last;

   always @(negedge clk) begin
      exp_t e;
      if (!rst_n) begin
         have_prev = 1'b0;
      end else begin
         if (have_prev)
            chk("stall_hold", {rk_valid, rk_last, rk_idx, rk},
                {1'b1, prev_last, prev_idx, prev_rk});
         have_prev = 1'b0;
         if (rk_valid) begin
            if (rk_ready) begin
               if (sb.size() == 0) begin
                  chk("unexpected_rk", {rk_idx, rk}, '0);
                  checks++; failures++;
                  $display("FAIL unexpected_rk transfer with empty scoreboard idx=%0d", rk_idx);
               end else begin
                  e = sb.pop_front();
                  chk("rk_stream", {busy, rk_last, rk_idx, rk}, {1'b1, e.last, e.idx, e.rk});
                  cap[rk_idx] = rk;
               end
            end else begin
               have_prev = 1'b1;
               prev_rk   = rk;
               prev_idx  = rk_idx;
               prev_last = rk_last;
            end
         end
      end
   end

   // ---- stimulus ----
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_key(input logic [4*W-1:0] mk, input int rdy_pct,
                          input bit inject5, input bit reset10, output int n);
      keys_t ks;
      int    w;
      n = 0;
      w = 0;
      while (!key_ready && w < 50) begin
         step();
         w++;
      end
      chk("key_ready_wait", {63'd0, key_ready}, 64'd1);
      ks = model_keys(mk);
      key       = mk;
      key_valid = 1'b1;
      for (int i = 0; i < R; i++) sb.push_back('{5'(i), ks[i], (i == R - 1)});
      step();
      key_valid = 1'b0;
      key       = '0;
      chk("first_latency", {rk_valid, busy, key_ready, rk_idx, rk},
          {1'b1, 1'b1, 1'b0, 5'd0, mk[15:0]});
      while (busy && n < 400) begin
         rk_ready = ($urandom_range(99) < rdy_pct);
         if (inject5 && rk_idx == 5'd5) begin
            key_valid = 1'b1;
            key       = 64'hFFFF_FFFF_FFFF_FFFF;
            chk("key_ready_in_run", {63'd0, key_ready}, 64'd0);
         end else begin
            key_valid = 1'b0;
            key       = '0;
         end
         if (reset10 && rk_idx == 5'd10) begin
            rst_n     = 1'b0;
            rk_ready  = 1'b0;
            key_valid = 1'b0;
            sb.delete();
            #1;
            chk("reset_midrun", {key_ready, rk_valid, rk_last, busy, rk_idx, rk}, '0);
            repeat (2) step();
            rst_n = 1'b1;
            step();
            return;
         end
         step();
         n++;
      end
      key_valid = 1'b0;
      rk_ready  = 1'b0;
      chk("run_timeout", {63'd0, busy}, 64'd0);
      chk("idle_after_last", {rk_valid, key_ready}, {1'b0, 1'b1});
      chk("scoreboard_drained", 64'(sb.size()), 64'd0);
   endtask

   localparam logic [63:0] KV = 64'h1918_1110_0908_0100;

   initial begin
      int n;
      keys_t got;
      rst_n     = 1'b0;
      key_valid = 1'b0;
      key       = '0;
      rk_ready  = 1'b0;
      have_prev = 1'b0;

      // Reset
      repeat (3) @(posedge clk);
      #1;
      chk("reset_outputs", {key_ready, rk_valid, rk_last, busy, rk_idx, rk}, '0);
      rst_n = 1'b1;
      #1;
      chk("key_ready_before_edge", {63'd0, key_ready}, 64'd0);
      step();
      chk("key_ready_after_edge", {busy, rk_valid, key_ready}, {1'b0, 1'b0, 1'b1});

      // Known vector, full throughput
      for (int i = 0; i < R; i++) cap[i] = '0;
      run_key(KV, 100, 1'b0, 1'b0, n);
      chk("back_to_back_cycles", 64'(n), 64'(R));
      chk("kv_rk0", 64'(cap[0]), 64'h0100);
      chk("kv_rk1", 64'(cap[1]), 64'h1512);
      for (int i = 0; i < R; i++) got[i] = cap[i];
      chk("speck_ciphertext", 64'(speck_encrypt(32'h6574_694C, got)), 64'hA868_42F2);

      // Backpressure, same key
      run_key(KV, 50, 1'b0, 1'b0, n);
      // Key offered during RUN must be ignored
      run_key(KV, 70, 1'b1, 1'b0, n);
      // Reset in the middle, then a fresh key
      run_key({$urandom, $urandom}, 60, 1'b0, 1'b1, n);
      run_key({$urandom, $urandom}, 100, 1'b0, 1'b0, n);
      chk("fresh_after_reset_cycles", 64'(n), 64'(R));

      // Random keys with random backpressure
      for (int t = 0; t < 6; t++)
         run_key({$urandom, $urandom}, 20 + 15 * t, 1'b0, 1'b0, n);

      repeat (3) step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
